trace_cmd_sequencer: RTL

Synthesizable, parametrised successor to the trace-driven stimulus path for the cache simulation. Accepts parsed trace records (command, address) from a file-reader front end over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Injects the initial reset command itself and issues records one per cycle to the cache model over a second valid/ready handshake. Filters illegal commands and raises `done` once end-of-trace is seen and the queue has drained.

---
 rtl/trace_pkg.sv | 28 ++
 rtl/trace_fifo.sv | 49 ++++
 rtl/trace_cmd_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the trace command sequencer: command codes, FSM states
// and the legal-command check.
package trace_pkg;

  localparam int unsigned CMD_RD  = 0;
  localparam int unsigned CMD_WR  = 1;
  localparam int unsigned CMD_IF  = 2;
  localparam int unsigned CMD_INV = 3;
  localparam int unsigned CMD_SNP = 4;
  localparam int unsigned CMD_CLR = 8;
  localparam int unsigned CMD_PRT = 9;

  typedef enum logic [1:0] {
    ST_INJ  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only the low nibble is examined; callers must reject nonzero upper bits.
  function automatic logic cmd_legal(input logic [3:0] cmd);
    case (cmd)
      4'(CMD_RD), 4'(CMD_WR), 4'(CMD_IF), 4'(CMD_INV),
      4'(CMD_SNP), 4'(CMD_CLR), 4'(CMD_PRT): cmd_legal = 1'b1;
      default:                               cmd_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers; DEPTH must be a power of two.
module trace_fifo #(
  parameter int unsigned DATA_W = 68,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level    = wr_ptr_q - rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/trace_cmd_sequencer.sv
// Trace record sequencer: injects a reset command, then issues buffered records.
// Optional TRACE_STATS_EN adds per-class issue counters.
module trace_cmd_sequencer
  import trace_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned CMD_W  = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CMD_W-1:0]       in_cmd,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic                   in_eof,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CMD_W-1:0]       out_cmd,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   done,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [CNT_W-1:0]       issue_cnt
`ifdef TRACE_STATS_EN
  ,
  output logic [CNT_W-1:0]       rd_cnt,
  output logic [CNT_W-1:0]       wr_cnt,
  output logic [CNT_W-1:0]       if_cnt,
  output logic [CNT_W-1:0]       snp_cnt
`endif
);

  localparam int unsigned DATA_W = CMD_W + ADDR_W;
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic              eof_seen_q, eof_seen_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_wdata, fifo_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              in_legal, no_addr, accept, issue, empty_after;
  logic [ADDR_W-1:0] push_addr;

  trace_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    eof_seen_d  = eof_seen_q;
    drop_cnt_d  = drop_cnt_q;
    issue_cnt_d = issue_cnt_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_cmd     = '0;
    out_addr    = '0;
    done        = 1'b0;
    fifo_pop    = 1'b0;

    in_legal   = ((in_cmd >> 4) == '0) && cmd_legal(in_cmd[3:0]);
    no_addr    = (in_cmd == CMD_W'(CMD_CLR)) || (in_cmd == CMD_W'(CMD_PRT));
    push_addr  = no_addr ? '0 : in_addr;
    fifo_wdata = {in_cmd, push_addr};

    // Outputs are forced to their reset values while rst_n is held low.
    if (rst_n) begin
      case (state_q)
        ST_INJ: begin
          in_ready  = !fifo_full;
          out_valid = 1'b1;
          out_cmd   = CMD_W'(CMD_CLR);
          if (out_ready) state_d = ST_RUN;
        end
        ST_RUN: begin
          in_ready              = !fifo_full;
          out_valid             = !fifo_empty;
          {out_cmd, out_addr}   = fifo_rdata;
          fifo_pop              = out_valid && out_ready;
        end
        ST_DONE: done = 1'b1;
        default: state_d = ST_INJ;
      endcase
    end

    accept    = in_valid && in_ready;
    fifo_push = accept && in_legal;
    issue     = out_valid && out_ready;

    if (accept && !in_legal) drop_cnt_d = sat_inc(drop_cnt_q);
    if (issue) issue_cnt_d = sat_inc(issue_cnt_q);
    if (rst_n && in_eof && state_q != ST_DONE) eof_seen_d = 1'b1;

    // Drain test looks at occupancy after this cycle's push/pop, using the
    // eof flag as it stood at the start of the cycle.
    empty_after = (fifo_empty && !fifo_push) ||
                  (fifo_level == LVL_W'(1) && fifo_pop && !fifo_push);
    if (rst_n && state_q == ST_RUN && eof_seen_q && empty_after) state_d = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INJ;
      eof_seen_q  <= 1'b0;
      drop_cnt_q  <= '0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      eof_seen_q  <= eof_seen_d;
      drop_cnt_q  <= drop_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign level     = fifo_level;
  assign drop_cnt  = drop_cnt_q;
  assign issue_cnt = issue_cnt_q;

`ifdef TRACE_STATS_EN
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] if_cnt_q, if_cnt_d, snp_cnt_q, snp_cnt_d;

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    if_cnt_d  = if_cnt_q;
    snp_cnt_d = snp_cnt_q;
    if (fifo_pop) begin
      if (out_cmd == CMD_W'(CMD_RD)) rd_cnt_d = sat_inc(rd_cnt_q);
      if (out_cmd == CMD_W'(CMD_WR)) wr_cnt_d = sat_inc(wr_cnt_q);
      if (out_cmd == CMD_W'(CMD_IF)) if_cnt_d = sat_inc(if_cnt_q);
      if (out_cmd == CMD_W'(CMD_INV) || out_cmd == CMD_W'(CMD_SNP)) snp_cnt_d = sat_inc(snp_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      if_cnt_q  <= '0;
      snp_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      if_cnt_q  <= if_cnt_d;
      snp_cnt_q <= snp_cnt_d;
    end
  end

  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign if_cnt  = if_cnt_q;
  assign snp_cnt = snp_cnt_q;
`endif

endmodule
